a2d_arb: RTL and testbench
==========================

A2D_ARB -- requirements
Module: a2d_arb

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum WAIT-state cycles allowed for one conversion before it is aborted.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0  input  1  conversion request, requester 0 (motion control); held high until done0.
REQ-005 chnl0  input  3  A2D channel requested by requester 0.
REQ-006 req1  input  1  conversion request, requester 1 (diagnostic/battery monitor); held high until done1.
REQ-007 chnl1  input  3  A2D channel requested by requester 1.
REQ-008 gnt0, gnt1  output  1 each  level; owner of the A2D for the current transaction.
REQ-009 done0, done1  output  1 each  one-cycle pulse; transaction complete for that owner.
REQ-010 err  output  1  valid only with a done pulse; 1 = conversion timed out.
REQ-011 res  output  12  last successful conversion result.
REQ-012 strt_cnv  output  1  one-cycle start pulse to the A2D interface.
REQ-013 chnnl  output  3  channel presented to the A2D interface.
REQ-014 cnv_cmplt  input  1  conversion complete from the A2D interface.
REQ-015 A2D_res  input  12  conversion data, valid while cnv_cmplt is high.

Function
REQ-016 The FSM SHALL have four states: IDLE, START, WAIT and DONE; all outputs are Moore or registered.
REQ-017 IDLE: when req0 or req1 is high, the block SHALL select a winner, latch its channel into chnnl, set that requester's gnt and move to START on the next edge.
REQ-018 Arbitration SHALL be round-robin: if both request, the winner is the requester not granted last; after reset, requester 0 wins a tie.
REQ-019 A lone requester SHALL be granted regardless of history, including back-to-back grants.
REQ-020 START: strt_cnv SHALL be high for exactly this one cycle; the timeout counter is cleared to 0; next state is WAIT.
REQ-021 WAIT: on cnv_cmplt=1, res SHALL load A2D_res, err is cleared and the next state is DONE.
REQ-022 WAIT: the counter SHALL increment each cycle; when cnt==TIMEOUT-1 and cnv_cmplt=0, err is set, res holds its value and the next state is DONE.
REQ-023 If cnv_cmplt and the timeout coincide, cnv_cmplt SHALL win: the result is captured and err=0.
REQ-024 DONE: the owner's done SHALL pulse for exactly one cycle; on the next edge gnt drops, the last-owner record updates and the state returns to IDLE.
REQ-025 Arbitration SHALL occur only in IDLE, so there is at least one IDLE cycle between transactions.
REQ-026 chnnl SHALL remain stable from START through DONE; chnl changes on the inputs during a transaction SHALL be ignored.
REQ-027 Deasserting the owner's req mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-028 cnv_cmplt outside WAIT SHALL be ignored.
REQ-029 Minimum latency SHALL be 4 cycles from req sampled in IDLE to the done pulse, reached when cnv_cmplt is high on the first WAIT cycle.
REQ-030 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.

Reset
REQ-031 With rst=1 at a clock edge, the state SHALL become IDLE; gnt0, gnt1, done0, done1, err and strt_cnv become 0; chnnl=0, res=0, the counter is 0 and the last-owner record is 1 (so requester 0 wins the first tie).
REQ-032 Reset asserted mid-transaction SHALL abort it with no done pulse; the request is re-arbitrated after rst is released.

Verification
REQ-033 Single request: req0=1, chnl0=3, cnv_cmplt high on the 5th WAIT cycle with A2D_res=0xABC -> gnt0 high, strt_cnv one pulse with chnnl=3, done0 one pulse with res=0xABC and err=0.
REQ-034 Tie and fairness: req0 and req1 held high continuously -> grants alternate 0,1,0,1; first grant to 0 after reset; never both gnt high.
REQ-035 Timeout: TIMEOUT=16, no cnv_cmplt -> done pulse 16 WAIT cycles after START, err=1, res unchanged.
REQ-036 Coincidence: cnv_cmplt asserted on the cycle where cnt==TIMEOUT-1 -> err=0, res captured.
REQ-037 Reset mid-WAIT: rst pulsed during WAIT -> all outputs at reset values, no done pulse; the pending req is granted 1 cycle after rst falls.
REQ-038 Input changes mid-transaction: chnl0 changed and req0 dropped during WAIT -> chnnl unchanged; done0 still pulses.

Source files
------------

// File: rtl/a2d_arb.sv
// a2d_arb: round-robin arbiter sharing one A2D converter between two requesters
module a2d_arb #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [2:0]  chnl0,
    input  logic        req1,
    input  logic [2:0]  chnl1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] A2D_res
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic last, pick1, timeout;
    always_comb begin
        pick1 = req1 & (~req0 | ~last);
        timeout = cnt == CW'(TIMEOUT - 1);
        nxt = state;
        strt_cnv = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        case (state)
            IDLE: nxt = (req0 | req1) ? START : IDLE;
            START: begin
                nxt = WAIT;
                strt_cnv = 1'b1;
            end
            WAIT: nxt = (cnv_cmplt | timeout) ? DONE : WAIT;
            DONE: begin
                nxt = IDLE;
                done0 = gnt0;
                done1 = gnt1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            err <= 1'b0;
            res <= '0;
            chnnl <= '0;
            cnt <= '0;
            last <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    gnt0 <= ~pick1;
                    gnt1 <= pick1;
                    chnnl <= pick1 ? chnl1 : chnl0;
                end
                START: begin
                    cnt <= '0;
                    err <= 1'b0;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnv_cmplt) begin
                        res <= A2D_res;
                        err <= 1'b0;
                    end else if (timeout) err <= 1'b1;
                end
                DONE: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    last <= gnt1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_arb.sv
// tb_a2d_arb: directed vector table plus hand sequences for timeout, coincidence and reset
module tb_a2d_arb;
    logic clk = 1'b0;
    logic rst, req0, req1, cnv_cmplt;
    logic [2:0] chnl0, chnl1;
    logic [11:0] A2D_res;
    logic gnt0, gnt1, done0, done1, err, strt_cnv;
    logic [11:0] res;
    logic [2:0] chnnl;
    int tests = 0, fails = 0;

    a2d_arb #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req0(req0), .chnl0(chnl0), .req1(req1), .chnl1(chnl1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err), .res(res),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, q0, q1, cc;
        logic [2:0] c0, c1;
        logic [11:0] ad;
        logic [20:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(int r, int q0, int c0, int q1, int c1, int cc, int ad,
                                int g0, int g1, int d0, int d1, int er, int st, int ch, int rs);
        vec_t v;
        v.r = r[0]; v.q0 = q0[0]; v.c0 = c0[2:0]; v.q1 = q1[0]; v.c1 = c1[2:0];
        v.cc = cc[0]; v.ad = ad[11:0];
        v.exp = {g0[0], g1[0], d0[0], d1[0], er[0], st[0], ch[2:0], rs[11:0]};
        return v;
    endfunction

    wire [20:0] outs = {gnt0, gnt1, done0, done1, err, strt_cnv, chnnl, res};

    task automatic tick();
        @(posedge clk);
        #1;
        tests++;
        if ((gnt0 && gnt1) || (done0 && done1)) begin
            fails++;
            $display("FAIL onehot: gnt=%b%b done=%b%b required at most one high", gnt0, gnt1, done0, done1);
        end
    endtask

    task automatic chk(input string name, input logic [20:0] exp);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL %s: got g/d/err/st/ch/res=%b_%b_%b_%b_%h_%h required %b_%b_%b_%b_%h_%h", name,
                     outs[20:19], outs[18:17], outs[16], outs[15], outs[14:12], outs[11:0],
                     exp[20:19], exp[18:17], exp[16], exp[15], exp[14:12], exp[11:0]);
        end
    endtask

    task automatic chk_v(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; chnl0 = '0; chnl1 = '0; cnv_cmplt = 1'b0; A2D_res = '0;
        // r q0 c0 q1 c1 cc ad | g0 g1 d0 d1 er st ch res
        tbl.push_back(mk(1,0,0,0,0,0,0,      0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0,0,      1,0,0,0,0,1,3,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,3,0,0,0,0,  1,0,0,0,0,0,3,0));
        tbl.push_back(mk(0,1,3,0,0,1,'hABC,  1,0,1,0,0,0,3,'hABC));
        tbl.push_back(mk(0,0,3,0,0,0,0,      0,0,0,0,0,0,3,'hABC));
        tbl.push_back(mk(1,1,1,1,5,0,0,      0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,5,0,0,      1,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,1,1,1,5,0,0,      1,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,1,5,1,'h111,  1,0,1,0,0,0,1,'h111));
        tbl.push_back(mk(0,1,1,1,5,0,0,      0,0,0,0,0,0,1,'h111));
        tbl.push_back(mk(0,1,1,1,5,0,0,      0,1,0,0,0,1,5,'h111));
        tbl.push_back(mk(0,1,1,1,5,0,0,      0,1,0,0,0,0,5,'h111));
        tbl.push_back(mk(0,1,1,1,5,1,'h222,  0,1,0,1,0,0,5,'h222));
        tbl.push_back(mk(0,1,1,1,5,0,0,      0,0,0,0,0,0,5,'h222));
        tbl.push_back(mk(0,1,1,1,5,0,0,      1,0,0,0,0,1,1,'h222));
        tbl.push_back(mk(0,1,1,1,5,0,0,      1,0,0,0,0,0,1,'h222));
        tbl.push_back(mk(0,1,1,1,5,1,'h333,  1,0,1,0,0,0,1,'h333));
        tbl.push_back(mk(0,1,1,1,5,0,0,      0,0,0,0,0,0,1,'h333));
        tbl.push_back(mk(0,1,1,1,5,0,0,      0,1,0,0,0,1,5,'h333));
        tbl.push_back(mk(0,1,1,1,5,0,0,      0,1,0,0,0,0,5,'h333));
        tbl.push_back(mk(0,1,1,1,5,1,'h444,  0,1,0,1,0,0,5,'h444));
        tbl.push_back(mk(0,0,1,0,5,0,0,      0,0,0,0,0,0,5,'h444));
        tbl.push_back(mk(0,0,0,1,6,1,'hEEE,  0,1,0,0,0,1,6,'h444));
        tbl.push_back(mk(0,0,0,1,6,1,'hDDD,  0,1,0,0,0,0,6,'h444));
        tbl.push_back(mk(0,0,0,1,6,1,'h555,  0,1,0,1,0,0,6,'h555));
        tbl.push_back(mk(0,0,0,1,6,1,'hFFF,  0,0,0,0,0,0,6,'h555));
        tbl.push_back(mk(0,0,0,1,6,0,0,      0,1,0,0,0,1,6,'h555));
        tbl.push_back(mk(0,0,0,1,6,0,0,      0,1,0,0,0,0,6,'h555));
        tbl.push_back(mk(0,0,0,1,6,1,'h666,  0,1,0,1,0,0,6,'h666));
        tbl.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,6,'h666));
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; req0 = tbl[i].q0; chnl0 = tbl[i].c0; req1 = tbl[i].q1;
            chnl1 = tbl[i].c1; cnv_cmplt = tbl[i].cc; A2D_res = tbl[i].ad;
            tick();
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // timeout: no cnv_cmplt
        req0 = 1'b1; chnl0 = 3'd2; cnv_cmplt = 1'b0; A2D_res = 12'h777;
        tick();
        chk("to_start", {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 12'h666});
        n = 0;
        do begin
            tick();
            n++;
        end while (!done0 && n < 40);
        chk_v("to_edges", n, 17);
        chk("to_done", {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 12'h666});
        req0 = 1'b0;
        tick();
        chk("to_idle", {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 12'h666});

        // cnv_cmplt on the last allowed WAIT cycle
        req1 = 1'b1; chnl1 = 3'd3;
        tick();
        chk("co_start", {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 12'h666});
        repeat (16) tick();
        chk_v("co_nodone", int'(done1), 0);
        cnv_cmplt = 1'b1; A2D_res = 12'h5A5;
        tick();
        chk("co_done", {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 12'h5A5});
        cnv_cmplt = 1'b0; req1 = 1'b0;
        tick();
        chk("co_idle", {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 12'h5A5});

        // reset in WAIT, then channel change and req drop mid-transaction
        req0 = 1'b1; chnl0 = 3'd4;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rs_a", '0);
        tick();
        chk("rs_b", '0);
        rst = 1'b0;
        tick();
        chk("rs_regrant", {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 12'h000});
        tick();
        chnl0 = 3'd7; req0 = 1'b0;
        tick();
        chk("chg_wait", {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 12'h000});
        cnv_cmplt = 1'b1; A2D_res = 12'h321;
        tick();
        chk("chg_done", {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 12'h321});
        cnv_cmplt = 1'b0;
        tick();
        chk("chg_idle", {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 12'h321});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
